// File: rtl/led_shift_ctrl.sv
// led_shift_ctrl
//   Control block for an N_LEDS-bit LED shift register. It produces the
//   one-cycle shift strobe from a four-rate prescaler, keeps the shift
//   direction (toggled by a debounced push-button), and tracks which LED is
//   lit. In bounce mode, the tracked position reverses the direction at the
//   ends, so the lit LED ping-pongs instead of wrapping.
//
// Ports
//   clk             system clock, all logic on posedge
//   i_ck_rst        asynchronous active-low reset
//   i_enable        run switch; 0 stops strobes and clears the prescaler
//   i_speed[1:0]    rate select, picks LIMIT_0..LIMIT_3
//   i_btn_dir       raw push-button, active high, asynchronous to clk
//   i_bounce        1 = ping-pong mode, 0 = wrap mode
//   o_shift_enable  registered one-cycle shift strobe
//   o_shift_dir     registered direction, 1 = DER (index--), 0 = IZQ (index++)
//   o_pos           registered index of the lit LED
module led_shift_ctrl #(
    parameter int                   N_LEDS     = 4,
    parameter int                   CNT_WIDTH  = 32,
    parameter logic [CNT_WIDTH-1:0] LIMIT_0    = CNT_WIDTH'(2**26 - 1),
    parameter logic [CNT_WIDTH-1:0] LIMIT_1    = CNT_WIDTH'(2**25 - 1),
    parameter logic [CNT_WIDTH-1:0] LIMIT_2    = CNT_WIDTH'(2**24 - 1),
    parameter logic [CNT_WIDTH-1:0] LIMIT_3    = CNT_WIDTH'(2**23 - 1),
    parameter int                   DEB_CYCLES = 16
) (
    input  logic                      clk,
    input  logic                      i_ck_rst,
    input  logic                      i_enable,
    input  logic [1:0]                i_speed,
    input  logic                      i_btn_dir,
    input  logic                      i_bounce,
    output logic                      o_shift_enable,
    output logic                      o_shift_dir,
    output logic [$clog2(N_LEDS)-1:0] o_pos
);

    localparam int POS_W = $clog2(N_LEDS);
    localparam int DEB_W = $clog2(DEB_CYCLES) + 1;

    localparam logic [POS_W-1:0] POS_LAST    = POS_W'(N_LEDS - 1);
    localparam logic [POS_W-1:0] POS_TURN_HI = POS_W'(N_LEDS - 2);
    localparam logic [POS_W-1:0] POS_TURN_LO = POS_W'(1);
    localparam logic [DEB_W-1:0] DEB_LAST    = DEB_W'(DEB_CYCLES - 1);

    typedef enum logic {
        IZQ = 1'b0,
        DER = 1'b1
    } dir_t;

    // ------------------------------------------------------------------
    // Prescaler
    // ------------------------------------------------------------------
    logic [CNT_WIDTH-1:0] limit;
    logic [CNT_WIDTH-1:0] count;

    always_comb begin
        limit = LIMIT_0;
        case (i_speed)
            2'd0: limit = LIMIT_0;
            2'd1: limit = LIMIT_1;
            2'd2: limit = LIMIT_2;
            2'd3: limit = LIMIT_3;
        endcase
    end

    // ">=" rather than "==" so that dropping to a smaller limit mid-count
    // fires on the next edge instead of running the counter round.
    always_ff @(posedge clk or negedge i_ck_rst) begin
        if (!i_ck_rst) begin
            count          <= '0;
            o_shift_enable <= 1'b0;
        end else if (!i_enable) begin
            count          <= '0;
            o_shift_enable <= 1'b0;
        end else if (count >= limit) begin
            count          <= '0;
            o_shift_enable <= 1'b1;
        end else begin
            count          <= count + CNT_WIDTH'(1);
            o_shift_enable <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Button: 2-flop synchronizer, debounce, rising-edge request
    // ------------------------------------------------------------------
    logic             sync_a;
    logic             sync_b;
    logic             deb_level;
    logic             deb_level_d;
    logic [DEB_W-1:0] deb_cnt;
    logic             btn_req;

    always_ff @(posedge clk or negedge i_ck_rst) begin
        if (!i_ck_rst) begin
            sync_a      <= 1'b0;
            sync_b      <= 1'b0;
            deb_level   <= 1'b0;
            deb_level_d <= 1'b0;
            deb_cnt     <= '0;
        end else begin
            sync_a      <= i_btn_dir;
            sync_b      <= sync_a;
            deb_level_d <= deb_level;
            if (sync_b != deb_level) begin
                if (deb_cnt == DEB_LAST) begin
                    deb_level <= sync_b;
                    deb_cnt   <= '0;
                end else begin
                    deb_cnt <= deb_cnt + DEB_W'(1);
                end
            end else begin
                deb_cnt <= '0;
            end
        end
    end

    // Press only; a release never requests a toggle.
    assign btn_req = deb_level & ~deb_level_d;

    // ------------------------------------------------------------------
    // Direction FSM and position tracker
    // ------------------------------------------------------------------
    dir_t dir_state;
    logic bounce_req;

    // Reverse one step before the end so the flip lands on the same edge
    // the lit LED reaches position N_LEDS-1 or 0.
    assign bounce_req = o_shift_enable & i_bounce &
                        (((dir_state == IZQ) && (o_pos == POS_TURN_HI)) ||
                         ((dir_state == DER) && (o_pos == POS_TURN_LO)));

    always_ff @(posedge clk or negedge i_ck_rst) begin
        if (!i_ck_rst) begin
            dir_state <= IZQ;
            o_pos     <= '0;
        end else begin
            // Simultaneous button and bounce requests still toggle once.
            if (btn_req || bounce_req) begin
                dir_state <= (dir_state == IZQ) ? DER : IZQ;
            end
            if (o_shift_enable) begin
                if (dir_state == IZQ) begin
                    o_pos <= (o_pos == POS_LAST) ? '0 : o_pos + POS_W'(1);
                end else begin
                    o_pos <= (o_pos == '0) ? POS_LAST : o_pos - POS_W'(1);
                end
            end
        end
    end

    assign o_shift_dir = (dir_state == DER);

endmodule

// File: tb/tb_led_shift_ctrl.sv
// Directed bench for led_shift_ctrl with N_LEDS=4, limits 7/5/3/1 and
// DEB_CYCLES=4. Outputs are sampled 1 time unit after each rising edge;
// inputs change at the same point so the next edge sees them.
module tb_led_shift_ctrl;

    logic       clk;
    logic       rst;
    logic       en;
    logic [1:0] speed;
    logic       btn;
    logic       bounce;
    logic       strobe;
    logic       dir;
    logic [1:0] pos;

    int total;
    int bad;
    int hits;

    int wrap_pos [5] = '{1, 2, 3, 0, 1};
    int der_pos  [4] = '{2, 1, 0, 3};
    int bnc_pos  [6] = '{1, 2, 3, 2, 1, 0};
    int bnc_dir  [6] = '{0, 0, 1, 1, 1, 0};

    led_shift_ctrl #(
        .N_LEDS    (4),
        .CNT_WIDTH (32),
        .LIMIT_0   (32'd7),
        .LIMIT_1   (32'd5),
        .LIMIT_2   (32'd3),
        .LIMIT_3   (32'd1),
        .DEB_CYCLES(4)
    ) dut (
        .clk           (clk),
        .i_ck_rst      (rst),
        .i_enable      (en),
        .i_speed       (speed),
        .i_btn_dir     (btn),
        .i_bounce      (bounce),
        .o_shift_enable(strobe),
        .o_shift_dir   (dir),
        .o_pos         (pos)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Counts edges until the strobe is seen high (bounded at 64).
    task automatic wait_strobe(input string tag, input int exp_n);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (strobe !== 1'b1 && n < 64);
        check(tag, n, exp_n);
    endtask

    initial begin
        total  = 0;
        bad    = 0;
        rst    = 1'b0;
        en     = 1'b0;
        speed  = 2'd2;
        btn    = 1'b0;
        bounce = 1'b0;

        // Reset state
        tick();
        tick();
        check("rst_strobe", strobe, 0);
        check("rst_dir", dir, 0);
        check("rst_pos", pos, 0);

        // Rate: speed 2 -> period 4, 1 cycle wide
        rst = 1'b1;
        en  = 1'b1;
        wait_strobe("first_strobe", 4);
        check("first_pos", pos, 0);
        tick();
        check("strobe_width", strobe, 0);
        check("pos_after_first", pos, 1);

        // Disable mid-count: no strobe, count restarts from 0
        tick();
        en   = 1'b0;
        hits = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (strobe === 1'b1) hits++;
        end
        check("disabled_no_strobe", hits, 0);
        en = 1'b1;
        wait_strobe("reenable_period", 4);
        check("wrap_pos0", pos, wrap_pos[0]);

        // Wrap mode, IZQ
        for (int i = 1; i < 5; i++) begin
            wait_strobe("wrap_period", 4);
            check("wrap_pos", pos, wrap_pos[i]);
        end
        check("wrap_dir", dir, 0);
        en = 1'b0;
        tick();
        check("pos_consumed", pos, 2);
        check("strobe_off", strobe, 0);

        // Glitch of 3 cycles: no toggle
        btn = 1'b1;
        tick();
        tick();
        tick();
        btn = 1'b0;
        repeat (12) tick();
        check("glitch_dir", dir, 0);

        // Clean press: toggle at edge 7 exactly
        btn = 1'b1;
        repeat (6) tick();
        check("press_edge6", dir, 0);
        tick();
        check("press_edge7", dir, 1);
        repeat (100) tick();
        check("held_dir", dir, 1);
        btn = 1'b0;
        repeat (20) tick();
        check("release_dir", dir, 1);

        // Wrap mode, DER
        en = 1'b1;
        wait_strobe("der_first", 4);
        check("der_pos0", pos, der_pos[0]);
        for (int i = 1; i < 4; i++) begin
            wait_strobe("der_period", 4);
            check("der_pos", pos, der_pos[i]);
        end
        check("der_dir", dir, 1);

        // Asynchronous reset with strobe/dir/pos all nonzero
        rst = 1'b0;
        #1;
        check("async_rst_strobe", strobe, 0);
        check("async_rst_dir", dir, 0);
        check("async_rst_pos", pos, 0);
        #1;
        rst = 1'b1;
        wait_strobe("post_rst_first", 4);
        check("post_rst_pos", pos, 0);

        // Bounce mode from pos 0, IZQ
        bounce = 1'b1;
        for (int i = 0; i < 6; i++) begin
            wait_strobe("bnc_period", 4);
            check("bnc_pos", pos, bnc_pos[i]);
            check("bnc_dir", dir, bnc_dir[i]);
        end

        // Collision: button toggle lands on the pos 2 -> 3 flip edge
        tick();
        tick();
        btn = 1'b1;
        repeat (6) tick();
        check("coll_pre_strobe", strobe, 1);
        check("coll_pre_pos", pos, 2);
        check("coll_pre_dir", dir, 0);
        tick();
        check("coll_pos", pos, 3);
        check("coll_dir", dir, 1);
        btn = 1'b0;
        repeat (20) tick();

        // Speed change to a smaller limit mid-count
        bounce = 1'b0;
        en     = 1'b0;
        tick();
        speed = 2'd0;
        en    = 1'b1;
        repeat (6) tick();
        check("speed_pre", strobe, 0);
        speed = 2'd3;
        tick();
        check("speed_switch", strobe, 1);
        tick();
        check("speed3_low", strobe, 0);
        tick();
        check("speed3_high", strobe, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
